// File: rtl/multicycle_control.sv
// Multicycle LEGv8-style main control FSM: sequences fetch, decode,
// R-type, load/store, CBZ and branch, and traps unsupported opcodes in HALT.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] opcode,
  input  logic        mem_ready,
  output logic [1:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        reg2_loc,
  output logic [1:0]  pc_source,
  output logic        illegal,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_R_WB      = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_CBZ       = 4'd8,
    S_JUMP      = 4'd9,
    S_HALT      = 4'd10
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  PFX_CBZ = 8'b10110100;
  localparam logic [5:0]  PFX_B   = 6'b000101;

  state_t state_q;
  state_t state_d;

  logic is_rtype;
  logic is_mem;
  logic is_stur;
  logic is_cbz;
  logic is_b;

  // Opcode classification; exact matches are disjoint from both prefixes.
  always_comb begin
    is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
               (opcode == OP_AND) || (opcode == OP_ORR);
    is_stur  = (opcode == OP_STUR);
    is_mem   = (opcode == OP_LDUR) || is_stur;
    is_cbz   = (opcode[10:3] == PFX_CBZ);
    is_b     = (opcode[10:5] == PFX_B);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic; unused encodings recover to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if      (is_rtype) state_d = S_EXEC_R;
        else if (is_mem)   state_d = S_MEM_ADDR;
        else if (is_cbz)   state_d = S_CBZ;
        else if (is_b)     state_d = S_JUMP;
        else               state_d = S_HALT;
      end
      S_EXEC_R:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_MEM_ADDR:  state_d = opcode[1] ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_CBZ:       state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // Moore control outputs, all forced low while reset is held.
  always_comb begin
    alu_op        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg2_loc      = 1'b0;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          pc_write  = mem_ready;
          ir_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          reg2_loc  = is_stur || is_cbz;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB:      reg_write = 1'b1;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_READ:  mem_read = 1'b1;
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          reg2_loc  = 1'b1;
        end
        S_CBZ: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          reg2_loc      = 1'b1;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_HALT:      illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 opcode  input  11  instruction[31:21], valid from DECODE onward (instruction register output).
REQ-005 mem_ready  input  1  memory handshake; 1 = current read/write completes this cycle.
REQ-006 alu_op  output  2  to ALU control: 00 add, 01 pass-B (CBZ zero test), 10 R-type funct decode.
REQ-007 alu_src_a  output  1  0 = PC, 1 = register A.
REQ-008 alu_src_b  output  2  00 reg B, 01 constant 4, 10 sign-extended D-immediate, 11 branch offset <<2.
REQ-009 pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, mem_to_reg, reg2_loc  output  1 each  datapath enables/selects.
REQ-010 pc_source  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
REQ-011 illegal  output  1  sticky flag: unsupported opcode decoded.
REQ-012 state  output  4  current state encoding, for debug and verification.

Function
REQ-013 The FSM SHALL use states FETCH=0, DECODE=1, EXEC_R=2, R_WB=3, MEM_ADDR=4, MEM_READ=5, MEM_WB=6, MEM_WRITE=7, CBZ=8, JUMP=9, HALT=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-014 Outputs SHALL be Moore (depend only on state), except pc_write and ir_write in FETCH, which SHALL equal mem_ready; every output not listed for a state SHALL be 0.
REQ-015 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; hold while mem_ready=0; go to DECODE on the edge where mem_ready=1.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; reg2_loc=1 if opcode is STUR or CBZ, else 0; one cycle.
REQ-017 DECODE transitions: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC_R; LDUR 11111000010, STUR 11111000000 -> MEM_ADDR; opcode[10:3]=10110100 -> CBZ; opcode[10:5]=000101 -> JUMP; any other value -> HALT.
REQ-018 Exact 11-bit matches SHALL take priority over prefix matches; no opcode SHALL match more than one class.
REQ-019 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB. R_WB: reg_write=1, mem_to_reg=0 -> FETCH.
REQ-020 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; -> MEM_READ for LDUR, -> MEM_WRITE for STUR (opcode[1] selects).
REQ-021 MEM_READ: mem_read=1; hold until mem_ready=1, then -> MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1 -> FETCH.
REQ-022 MEM_WRITE: mem_write=1, reg2_loc=1; hold until mem_ready=1, then -> FETCH.
REQ-023 CBZ: alu_src_a=1, alu_src_b=00, alu_op=01, reg2_loc=1, pc_write_cond=1, pc_source=01 -> FETCH.
REQ-024 JUMP: pc_write=1, pc_source=10 -> FETCH.
REQ-025 HALT: illegal=1, all enables 0; HALT SHALL be absorbing until rst.
REQ-026 Instruction latency in cycles (mem_ready always 1): R-type 4, LDUR 5, STUR 4, CBZ 3, B 3; each wait cycle adds one.
REQ-027 mem_read and mem_write SHALL never be 1 in the same cycle; reg_write SHALL never coincide with pc_write.

Reset
REQ-028 rst=1 SHALL immediately force state=FETCH, illegal=0, and all outputs to 0 (FETCH enables suppressed) regardless of clk.
REQ-029 After rst deasserts, the first rising edge SHALL evaluate FETCH normally; rst asserted mid-instruction SHALL abandon it with no further reg_write/mem_write/pc_write.

Verification
REQ-030 ADD (10001011000), mem_ready=1 -> states 0,1,2,3,0; alu_op=10 in state 2; reg_write=1 only in state 3.
REQ-031 LDUR with mem_ready low 2 cycles in MEM_READ -> states 0,1,4,5,5,5,6,0; mem_to_reg=1 and reg_write=1 only in state 6.
REQ-032 STUR, then CBZ (opcode 10110100xxx), then B (000101xxxxx) -> MEM_WRITE mem_write=1; CBZ alu_op=01, pc_write_cond=1, pc_source=01; JUMP pc_write=1, pc_source=10.
REQ-033 FETCH with mem_ready=0 for 3 cycles -> state stays 0, pc_write=ir_write=0 until mem_ready=1, then both 1 for one cycle.
REQ-034 Opcode 11111111111 in DECODE -> state 10, illegal=1 held indefinitely; rst pulse -> state 0, illegal=0 asynchronously.
REQ-035 rst asserted between clock edges during MEM_WRITE -> mem_write drops to 0 before the next edge; state=0.
